// File: rtl/alu_ctrl_seq.sv
// Multi-cycle ALU control sequencer: latches opcode/shift amount on start and
// drives registered ALU select lines. Build option: ALU_CTRL_ROTATE_EN (opcode 111 = ROL).
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | single-step add/sub/logic operation
// SHIFT | one 1-bit shift step per cycle, down-counter running
// FIN   | done pulse; may accept a back-to-back start
module alu_ctrl_seq #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               step_en,
  output logic               bsel,
  output logic               cisel,
  output logic [1:0]         osel,
  output logic               shift_la,
  output logic               shift_lr,
  output logic               logical_op
);

  if (SHAMT_W != $clog2(DATA_W)) begin : g_bad_shamt_w
    $error("alu_ctrl_seq: SHAMT_W must equal clog2(DATA_W)");
  end

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, FIN} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [6:0]         ctl_q;
  logic [6:0]         ctl_d;
  logic               shift_d;
  logic               illegal_d;

  // ctl vector: {bsel, cisel, osel[1:0], shift_la, shift_lr, logical_op}
  always_comb begin
    ctl_d     = 7'b0000000;
    shift_d   = 1'b0;
    illegal_d = 1'b0;
    case (op)
      3'b000: ctl_d = 7'b0000000;
      3'b001: ctl_d = 7'b1100000;
      3'b010: begin ctl_d = 7'b0001100; shift_d = 1'b1; end
      3'b011: begin ctl_d = 7'b0001010; shift_d = 1'b1; end
      3'b100: begin ctl_d = 7'b0001000; shift_d = 1'b1; end
      3'b101: ctl_d = 7'b0010001;
      3'b110: ctl_d = 7'b0010000;
      default: begin
`ifdef ALU_CTRL_ROTATE_EN
        ctl_d   = 7'b0001110;
        shift_d = 1'b1;
`else
        illegal_d = 1'b1;
`endif
      end
    endcase
  end

  assign {bsel, cisel, osel, shift_la, shift_lr, logical_op} = ctl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ctl_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      step_en <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            ctl_q   <= ctl_d;
            illegal <= illegal_d;
            if (illegal_d || (shift_d && shamt == '0)) begin
              // nothing to execute: complete in the very next cycle
              state   <= FIN;
              cnt     <= '0;
              done    <= 1'b1;
              busy    <= 1'b0;
              step_en <= 1'b0;
            end else if (shift_d) begin
              state   <= SHIFT;
              cnt     <= shamt;
              done    <= 1'b0;
              busy    <= 1'b1;
              step_en <= 1'b1;
            end else begin
              state   <= EXEC;
              cnt     <= '0;
              done    <= 1'b0;
              busy    <= 1'b1;
              step_en <= 1'b1;
            end
          end else begin
            state   <= IDLE;
            done    <= 1'b0;
            illegal <= 1'b0;
            busy    <= 1'b0;
            step_en <= 1'b0;
          end
        end
        EXEC: begin
          state   <= FIN;
          done    <= 1'b1;
          busy    <= 1'b0;
          step_en <= 1'b0;
        end
        SHIFT: begin
          if (cnt == SHAMT_W'(1)) begin
            state   <= FIN;
            cnt     <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            step_en <= 1'b0;
          end else begin
            cnt <= cnt - SHAMT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          step_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver pushes expected completions,
// a negedge monitor checks step pulses and each done pulse against the queue.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] shamt = 4'd0;
  logic       busy, done, illegal, step_en, bsel, cisel, shift_la, shift_lr, logical_op;
  logic [1:0] osel;

  alu_ctrl_seq #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt),
    .busy(busy), .done(done), .illegal(illegal), .step_en(step_en),
    .bsel(bsel), .cisel(cisel), .osel(osel), .shift_la(shift_la),
    .shift_lr(shift_lr), .logical_op(logical_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] fields;
    logic       ill;
    int         steps;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   steps_seen = 0;
  int   dones = 0;

  wire [6:0]  f    = {bsel, cisel, osel, shift_la, shift_lr, logical_op};
  wire [10:0] outs = {busy, done, illegal, step_en, f};

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_matches_step", int'(busy), int'(step_en));
      chk("illegal_only_with_done", int'(illegal & ~done), 0);
      if (step_en) begin
        steps_seen++;
        if (sb.size() > 0) chk({sb[0].name, "_step_fields"}, int'(f), int'(sb[0].fields));
        else chk("unexpected_step", 1, 0);
      end
      if (done) begin
        exp_t e;
        dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
          chk({e.name, "_steps"}, steps_seen, e.steps);
          chk({e.name, "_illegal"}, int'(illegal), int'(e.ill));
          chk({e.name, "_done_fields"}, int'(f), int'(e.fields));
        end
        steps_seen = 0;
      end
    end
  end

  // Called #1 after a rising edge; start is sampled on the next edge.
  task automatic issue(string nm, logic [2:0] o, logic [3:0] sh, logic [6:0] fx,
                       logic ill, int steps, int lat);
    exp_t e;
    start = 1'b1;
    op    = o;
    shamt = sh;
    e.name = nm; e.fields = fx; e.ill = ill; e.steps = steps;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", int'(outs), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("sub", 3'b001, 4'd0, 7'b1100000, 1'b0, 1, 2);
    wait_idle();

    issue("sra5", 3'b010, 4'd5, 7'b0001100, 1'b0, 5, 6);
    wait_idle();
    issue("sra15", 3'b010, 4'd15, 7'b0001100, 1'b0, 15, 16);
    wait_idle();

    issue("sll0", 3'b100, 4'd0, 7'b0001000, 1'b0, 0, 1);
    wait_idle();

    // start held through the busy part of an SRL must be ignored
    issue("srl3", 3'b011, 4'd3, 7'b0001010, 1'b0, 3, 4);
    start = 1'b1; op = 3'b001; shamt = 4'd7;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    chk("srl_fields_held", int'(f), int'(7'b0001010));

    d0 = dones;
    issue("add", 3'b000, 4'd0, 7'b0000000, 1'b0, 1, 2);
    @(posedge clk); #1;
    issue("and_b2b", 3'b101, 4'd0, 7'b0010001, 1'b0, 1, 2);
    wait_idle();
    repeat (3) @(posedge clk);
    chk("b2b_done_count", dones - d0, 2);

    #1 issue("srl9", 3'b011, 4'd9, 7'b0001010, 1'b0, 9, 10);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("steps_before_reset", steps_seen, 4);
    rst_n = 1'b0;
    sb.delete();
    steps_seen = 0;
    #1 chk("reset_mid_outputs", int'(outs), 0);
    repeat (2) @(posedge clk);
    #1 chk("reset_held_outputs", int'(outs), 0);
    rst_n = 1'b1;
    d0 = dones;
    @(posedge clk); #1;
    chk("no_done_after_abort", dones - d0, 0);
    issue("or", 3'b110, 4'd0, 7'b0010000, 1'b0, 1, 2);
    wait_idle();

`ifdef ALU_CTRL_ROTATE_EN
    issue("rol3", 3'b111, 4'd3, 7'b0001110, 1'b0, 3, 4);
`else
    issue("illegal111", 3'b111, 4'd3, 7'b0000000, 1'b1, 0, 1);
`endif
    wait_idle();

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, multi-cycle ALU control sequencer for the microprocessor datapath. It latches a 3-bit opcode and a shift amount on a START handshake and drives the ALU select lines. Shifts are executed as one 1-bit step per cycle against a datapath accumulator. It signals completion with a one-cycle DONE pulse, and all don't-care control fields are driven to deterministic zeros.

## Interface
- DATA_W, 16: datapath width; sets maximum shift count.
- SHAMT_W, 4: shift-amount width; must equal $clog2(DATA_W).

- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; accepted only when BUSY=0.
- OP  in  3  opcode, sampled on accept.
- SHAMT  in  SHAMT_W  shift count, sampled on accept; used only for shifts.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle completion pulse.
- ILLEGAL  out  1  valid with DONE; opcode was unsupported.
- STEP_EN  out  1  datapath accumulator load enable, one pulse per execution step.
- BSEL, CISEL  out  1 each  adder B-invert select and carry-in select.
- OSEL  out  2  result mux: 00 adder, 01 shifter, 10 logic.
- SHIFT_LA, SHIFT_LR  out  1 each  shifter mode.
- LOGICAL_OP  out  1  1 = AND, 0 = OR.

## Operation
- FSM states: IDLE, EXEC, SHIFT, FIN. The reset state is IDLE.
- Accept condition: START=1 in IDLE or FIN. On accept, latch OP and SHAMT into internal registers.
- Control fields are registered outputs, decoded from the latched OP. They update on accept and hold until the next accept.
- Opcode decode (fields not listed are 0):
  - 000 ADD: BSEL=0, CISEL=0, OSEL=00.
  - 001 SUB: BSEL=1, CISEL=1, OSEL=00.
  - 010 SRA: OSEL=01, SHIFT_LA=1, SHIFT_LR=0.
  - 011 SRL: OSEL=01, SHIFT_LA=0, SHIFT_LR=1.
  - 100 SLL: OSEL=01, SHIFT_LA=0, SHIFT_LR=0.
  - 101 AND: OSEL=10, LOGICAL_OP=1.
  - 110 OR: OSEL=10, LOGICAL_OP=0.
  - 111: illegal, all fields 0 (see Configuration).
- Transitions on accept:
  - ADD, SUB, AND, OR go to EXEC.
  - Shift with SHAMT>0 goes to SHIFT, with the down-counter loaded to SHAMT.
  - Shift with SHAMT=0 goes to FIN; the datapath holds the unshifted operand.
  - Illegal opcode goes to FIN with ILLEGAL=1.
- EXEC: STEP_EN=1 for one cycle, then go to FIN.
- SHIFT: STEP_EN=1 every cycle and the counter decrements each cycle. When counter==1, go to FIN.
- FIN: DONE=1 and BUSY=0 for exactly one cycle. Go to IDLE, or accept a new START (back-to-back).
- ILLEGAL is 1 only in FIN of an illegal operation; 0 otherwise.
- START while BUSY=1 is ignored: no latch and no effect on the current operation.

## Timing
- Accept at edge n gives:
  - ALU/logic op: STEP_EN in cycle n+1, DONE in cycle n+2.
  - Shift by k>0: STEP_EN in cycles n+1..n+k, DONE in cycle n+k+1.
  - Shift by 0, or illegal: DONE in cycle n+1, with no STEP_EN.
- BUSY is high from cycle n+1 until the cycle before DONE.
- Maximum shift is DATA_W-1 steps. The counter never wraps.
- Back-to-back: START in the FIN cycle gives the next operation's first step in the following cycle, with no idle gap.
- Reset asserted at any time, including mid-shift:
  - Immediately returns the FSM to IDLE and clears the counter.
  - All outputs go to 0 and no DONE is emitted for the aborted operation.
- Reset values: every output is 0.

## Configuration
- ALU_CTRL_ROTATE_EN defined: opcode 111 is ROL.
  - Fields: OSEL=01, SHIFT_LA=1, SHIFT_LR=1.
  - Sequenced exactly like the other shifts using SHAMT. ILLEGAL is never asserted.
- ALU_CTRL_ROTATE_EN undefined: opcode 111 is illegal. It completes in one cycle with DONE=1 and ILLEGAL=1, and no STEP_EN.

## Test plan
- Reset, then START with OP=001 → cycle n+1: BSEL=1, CISEL=1, OSEL=00, STEP_EN=1, BUSY=1; cycle n+2: DONE=1, BUSY=0.
- OP=010, SHAMT=5 → STEP_EN high for exactly 5 consecutive cycles with OSEL=01, SHIFT_LA=1, SHIFT_LR=0; DONE in the 6th cycle. Then repeat with SHAMT=15 → 15 steps.
- OP=100, SHAMT=0 → DONE in cycle n+1 with no STEP_EN. START held high during BUSY of a preceding SRL by 3 → ignored, with no change to the latched fields.
- Back-to-back: START with OP=101 in the FIN cycle of an ADD → STEP_EN on the next cycle with OSEL=10 and LOGICAL_OP=1; exactly two DONE pulses in total.
- Assert RST_N=0 mid-way through an SRL by 9 (after 4 steps) → all outputs 0 immediately and no DONE; after release, a fresh OP=110 works normally.
- OP=111 with SHAMT=3:
  - Without ALU_CTRL_ROTATE_EN: DONE=1 and ILLEGAL=1 at n+1, all fields 0.
  - With ALU_CTRL_ROTATE_EN: 3 steps with SHIFT_LA=1 and SHIFT_LR=1, then DONE with ILLEGAL=0.
